// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
//   Tick-driven pushbutton debouncer. The raw button level is brought into the
//   clock domain through a two-flop synchronizer, then a four-state FSM only
//   accepts a level change once the synchronized input has stayed stable for
//   STABLE_TICKS consecutive tick_in pulses. While a change is being qualified
//   the FSM enables the external time_ticker through timer_en.
//
//   Optional feature macro: DEBOUNCE_PRESS_COUNT_EN
//     defined   -> press_count counts accepted presses (wraps at 2^COUNT_WIDTH)
//     undefined -> press_count is tied to zero, no counter flops
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   noisy_in     in   raw asynchronous button level
//   tick_in      in   one-cycle strobe from time_ticker done
//   timer_en     out  enable for time_ticker (high while qualifying)
//   db_level     out  debounced level
//   rise_pulse   out  one-cycle strobe on db_level 0->1
//   fall_pulse   out  one-cycle strobe on db_level 1->0
//   press_count  out  number of accepted presses
// ---------------------------------------------------------------------------
module debounce_fsm #(
  parameter int STABLE_TICKS = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   noisy_in,
  input  logic                   tick_in,
  output logic                   timer_en,
  output logic                   db_level,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int              CW   = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            s;
  logic            timer_en_q, db_level_q, rise_q, fall_q;
  logic            timer_en_d, db_level_d, rise_d, fall_d;

  // Two-flop synchronizer; the FSM only ever looks at s.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= noisy_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ZERO;
      cnt_q      <= '0;
      timer_en_q <= 1'b0;
      db_level_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_en_q <= timer_en_d;
      db_level_q <= db_level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // A reversal of s is tested before tick_in so a bounce that coincides with
  // a tick restarts qualification instead of accepting the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (tick_in) begin
          if (cnt_q == LAST) begin
            state_d = ONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (tick_in) begin
          if (cnt_q == LAST) begin
            state_d = ZERO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    timer_en_d = (state_d == WAIT1) || (state_d == WAIT0);
    db_level_d = (state_d == ONE)   || (state_d == WAIT0);
    rise_d     = (state_q == WAIT1) && (state_d == ONE);
    fall_d     = (state_q == WAIT0) && (state_d == ZERO);
  end

  assign timer_en   = timer_en_q;
  assign db_level   = db_level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef DEBOUNCE_PRESS_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  // Counts in step with rise_pulse so press_count is already updated while
  // the strobe is high; natural wrap at the top of the range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (rise_d) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign press_count = count_q;
`else
  assign press_count = '0;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_debounce_fsm
//   Directed bench for debounce_fsm (STABLE_TICKS=4, tick every 10 clocks).
//   Stimulus pushes each expected strobe (kind, cycle, count) into a queue;
//   a monitor pops and compares whenever rise_pulse or fall_pulse appears.
// ---------------------------------------------------------------------------
module tb_debounce_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       noisy_in = 1'b1;
  logic       tick_in = 1'b0;
  logic       timer_en, db_level, rise_pulse, fall_pulse;
  logic [7:0] press_count;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_strobe = 1'b0;

  typedef struct {
    logic       is_rise;
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  debounce_fsm #(
    .STABLE_TICKS (4),
    .COUNT_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .noisy_in    (noisy_in),
    .tick_in     (tick_in),
    .timer_en    (timer_en),
    .db_level    (db_level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // tick_in is sampled at every posedge that brings cyc to a multiple of 10.
  always @(negedge clk) tick_in = ((cyc + 1) % 10 == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n !== 1'b1) begin
      prev_strobe = 1'b0;
    end else begin
      if (rise_pulse || fall_pulse) begin
        check("strobe_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
        check("strobe_not_consecutive", 32'(prev_strobe), 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: rise=%0b fall=%0b at cyc %0d, none expected",
                   rise_pulse, fall_pulse, cyc);
        end else begin
          e = q.pop_front();
          check("strobe_kind_rise", 32'(rise_pulse), 32'(e.is_rise));
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("strobe_level", 32'(db_level), 32'(e.is_rise));
          check("strobe_count", 32'(press_count), 32'(e.cnt));
        end
      end
      prev_strobe = rise_pulse | fall_pulse;
    end
  end

  // Returns on a negedge where tick_in has just been raised.
  task automatic align();
    @(negedge clk);
    while ((cyc + 1) % 10 != 0) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Change on a tick-aligned negedge c: WAIT state from edge c+3, ticks at
  // c+11, c+21, c+31, c+41 -> strobe visible at the negedge with cyc == c+41.
  task automatic press();
    int c;
    align();
    c = cyc;
    noisy_in = 1'b1;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    exp_cnt = exp_cnt + 8'd1;
`endif
    q.push_back('{is_rise: 1'b1, cyc: c + 41, cnt: exp_cnt});
    wait_until(c + 41);
    check("press_level", 32'(db_level), 32'd1);
    check("press_timer_off", 32'(timer_en), 32'd0);
  endtask

  task automatic release_btn();
    int c;
    align();
    c = cyc;
    noisy_in = 1'b0;
    q.push_back('{is_rise: 1'b0, cyc: c + 41, cnt: exp_cnt});
    wait_until(c + 41);
    check("release_level", 32'(db_level), 32'd0);
    check("release_timer_off", 32'(timer_en), 32'd0);
  endtask

  initial begin
    int c;
    int k;

    // Reset held with the button already pressed.
    repeat (4) @(negedge clk);
    check("rst_timer_en", 32'(timer_en), 32'd0);
    check("rst_db_level", 32'(db_level), 32'd0);
    check("rst_strobes", 32'({rise_pulse, fall_pulse}), 32'd0);
    check("rst_press_count", 32'(press_count), 32'd0);

    // Release reset on a tick boundary: WAIT1 within 3 clocks, rise at c+41.
    align();
    c = cyc;
    reset_n = 1'b1;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    exp_cnt = exp_cnt + 8'd1;
`endif
    q.push_back('{is_rise: 1'b1, cyc: c + 41, cnt: exp_cnt});
    k = 0;
    while (!timer_en && k < 3) begin
      @(negedge clk);
      k++;
    end
    check("post_rst_timer_en", 32'(timer_en), 32'd1);
    check("post_rst_level_low", 32'(db_level), 32'd0);
    wait_until(c + 41);
    check("clean_press_level", 32'(db_level), 32'd1);
    check("clean_press_timer_off", 32'(timer_en), 32'd0);
    repeat (5) @(negedge clk);

    // Clean release from ONE.
    release_btn();
    repeat (5) @(negedge clk);

    // Bounce every 7 clocks for 200 clocks, hold low briefly, then settle high.
    for (int i = 0; i < 200; i++) begin
      noisy_in = ((i / 7) % 2 == 0);
      @(negedge clk);
    end
    noisy_in = 1'b0;
    repeat (3) @(negedge clk);
    check("bounce_level_low", 32'(db_level), 32'd0);
    press();
    repeat (5) @(negedge clk);
    release_btn();
    repeat (5) @(negedge clk);

    // Reversal landing on the 4th tick: s drops at the same edge as tick 4.
    align();
    c = cyc;
    noisy_in = 1'b1;
    wait_until(c + 38);
    noisy_in = 1'b0;
    wait_until(c + 40);
    check("rev_still_waiting", 32'(timer_en), 32'd1);
    wait_until(c + 41);
    check("rev_level_low", 32'(db_level), 32'd0);
    check("rev_timer_off", 32'(timer_en), 32'd0);
    repeat (50) @(negedge clk);
    check("rev_level_stays_low", 32'(db_level), 32'd0);

    // Press, then reset while qualifying the release.
    press();
    repeat (5) @(negedge clk);
    c = cyc;
    noisy_in = 1'b0;
    wait_until(c + 20);
    check("wait0_timer_en", 32'(timer_en), 32'd1);
    check("wait0_level_high", 32'(db_level), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(db_level), 32'd0);
    check("mid_rst_timer", 32'(timer_en), 32'd0);
    check("mid_rst_strobes", 32'({rise_pulse, fall_pulse}), 32'd0);
    check("mid_rst_count", 32'(press_count), 32'd0);
    exp_cnt = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("after_rst_level", 32'(db_level), 32'd0);
    check("after_rst_timer", 32'(timer_en), 32'd0);

`ifdef DEBOUNCE_PRESS_COUNT_EN
    // 256 presses from a cleared counter wrap it back to zero.
    for (int i = 0; i < 256; i++) begin
      press();
      release_btn();
    end
    check("count_wrap", 32'(press_count), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time bound at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
